// File: rtl/instr_fetch_responder.sv
// Fetch responder: instruction store, output register + one-entry skid buffer,
// and branch decode on the consumed response word.
module instr_fetch_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [63:0]   req_addr,
    output logic          req_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic [63:0]   rsp_addr,
    output logic          rsp_err,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    output logic [63:0]   add,
    output logic          branch_taken
);

    logic [31:0] mem_q [DEPTH];

    logic        out_vld_q, out_vld_d, out_err_q, out_err_d;
    logic [31:0] out_data_q, out_data_d;
    logic [63:0] out_addr_q, out_addr_d;
    logic        skid_vld_q, skid_vld_d, skid_err_q, skid_err_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [63:0] skid_addr_q, skid_addr_d;
    logic [63:0] add_q, add_d;
    logic        bt_q, bt_d;

    logic        accept, consume, is_br, oob;
    logic [31:0] rd_word;

    // Store is never reset; a same-cycle read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign accept  = req_valid && !skid_vld_q;
    assign consume = out_vld_q && rsp_ready;
    assign is_br   = consume && !out_err_q && (out_data_q[31:24] == 8'hB0);
    assign oob     = (req_addr >= 64'(DEPTH));
    assign rd_word = oob ? 32'h0000_0000 : mem_q[req_addr[AW-1:0]];

    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_addr_d = skid_addr_q;
        skid_err_d  = skid_err_q;
        add_d       = is_br ? {{40{out_data_q[23]}}, out_data_q[23:0]} : 64'd0;
        bt_d        = is_br;
        if (is_br) begin
            // Everything behind a taken branch is wrong-path, including this cycle's accept.
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || consume) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = skid_data_q;
                out_addr_d = skid_addr_q;
                out_err_d  = skid_err_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_vld_d  = 1'b1;
                out_data_d = rd_word;
                out_addr_d = req_addr;
                out_err_d  = oob;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_data_d = rd_word;
            skid_addr_d = req_addr;
            skid_err_d  = oob;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_q   <= 1'b0;
            out_data_q  <= 32'd0;
            out_addr_q  <= 64'd0;
            out_err_q   <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= 32'd0;
            skid_addr_q <= 64'd0;
            skid_err_q  <= 1'b0;
            add_q       <= 64'd0;
            bt_q        <= 1'b0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_addr_q <= skid_addr_d;
            skid_err_q  <= skid_err_d;
            add_q       <= add_d;
            bt_q        <= bt_d;
        end
    end

    assign req_ready    = !skid_vld_q;
    assign rsp_valid    = out_vld_q;
    assign rsp_data     = out_data_q;
    assign rsp_addr     = out_addr_q;
    assign rsp_err      = out_err_q;
    assign add          = add_q;
    assign branch_taken = bt_q;

endmodule
